// File: rtl/csa_reduce_accum.sv
// Signed reduction of NUM_IN words per beat (3:2 tree + CPA), accumulated per packet, then rounded and saturated.
// Latency 3 cycles from last-beat acceptance to out_valid; a stalled output freezes every stage (in_ready = ~out_valid | out_ready).
module csa_reduce_accum #(
    parameter int NUM_IN    = 64,
    parameter int IN_BITS   = 16,
    parameter int OUT_BITS  = 16,
    parameter int SHIFT     = 0,
    parameter int MAX_BEATS = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               in_last,
    input  logic [NUM_IN*IN_BITS-1:0]          in_flat,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OUT_BITS-1:0]                out,
    output logic                               out_sat,
    output logic                               out_err,
    output logic [$clog2(MAX_BEATS+1)-1:0]     out_beats
);
    localparam int ACC_BITS = IN_BITS + $clog2(NUM_IN) + $clog2(MAX_BEATS);
    localparam int CNT_BITS = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_BEATS);
    localparam logic signed [ACC_BITS:0] RND =
        (SHIFT > 0) ? ((ACC_BITS+1)'(1) <<< (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [ACC_BITS:0] MAX_OUT =
        {{(ACC_BITS+2-OUT_BITS){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS:0] MIN_OUT =
        {{(ACC_BITS+2-OUT_BITS){1'b1}}, {(OUT_BITS-1){1'b0}}};

    function automatic int csa_layers(input int n);
        int cnt = n;
        int l   = 0;
        while (cnt > 2) begin
            cnt = 2 * (cnt / 3) + cnt % 3;
            l++;
        end
        return l;
    endfunction

    localparam int LAYERS = csa_layers(NUM_IN);

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Two spare slots keep the g+1/g+2 taps in range for the last group.
    logic [ACC_BITS-1:0] cur [NUM_IN+2];
    logic [ACC_BITS-1:0] nxt [NUM_IN+2];
    logic [ACC_BITS-1:0] ca, cb, cc;
    logic [ACC_BITS-1:0] csa_sum, csa_carry;
    int                  n_live;

    always_comb begin
        for (int i = 0; i < NUM_IN + 2; i++) begin
            cur[i] = '0;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            cur[i] = ACC_BITS'($signed(in_flat[i*IN_BITS +: IN_BITS]));
        end
        nxt    = cur;
        ca     = '0;
        cb     = '0;
        cc     = '0;
        n_live = NUM_IN;
        for (int l = 0; l < LAYERS; l++) begin
            nxt = cur;
            for (int g = 0; g < NUM_IN; g += 3) begin
                if (g + 2 < n_live) begin
                    ca = cur[g];
                    cb = cur[g+1];
                    cc = cur[g+2];
                    nxt[2*(g/3)]   = ca ^ cb ^ cc;
                    nxt[2*(g/3)+1] = ((ca & cb) | (ca & cc) | (cb & cc)) << 1;
                end else if (g < n_live) begin
                    nxt[2*(g/3)] = cur[g];
                    if (g + 1 < n_live) begin
                        nxt[2*(g/3)+1] = cur[g+1];
                    end
                end
            end
            n_live = 2 * (n_live / 3) + n_live % 3;
            cur    = nxt;
        end
        csa_sum   = cur[0];
        csa_carry = cur[1];
    end

    logic                s1_valid, s1_last;
    logic [ACC_BITS-1:0] s1_sum, s1_carry;
    logic                s2_valid, s2_last;
    logic [ACC_BITS-1:0] s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
            s1_carry <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2       <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            s1_sum   <= csa_sum;
            s1_carry <= csa_carry;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2       <= s1_sum + s1_carry;
        end
    end

    logic [ACC_BITS-1:0] acc, acc_sum, res;
    logic [CNT_BITS-1:0] beat_cnt, beat_nxt, res_beats;
    logic                res_valid, res_err;

    assign acc_sum  = acc + s2;
    assign beat_nxt = beat_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            beat_cnt  <= '0;
            res       <= '0;
            res_err   <= 1'b0;
            res_beats <= '0;
            res_valid <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            beat_cnt  <= '0;
            res_valid <= 1'b0;
        end else if (adv) begin
            if (s2_valid && (s2_last || beat_nxt == MAX_CNT)) begin
                res       <= acc_sum;
                res_err   <= ~s2_last;
                res_beats <= beat_nxt;
                res_valid <= 1'b1;
                acc       <= '0;
                beat_cnt  <= '0;
            end else begin
                res_valid <= 1'b0;
                if (s2_valid) begin
                    acc      <= acc_sum;
                    beat_cnt <= beat_nxt;
                end
            end
        end
    end

    // One extra bit so the rounding increment cannot wrap.
    logic signed [ACC_BITS:0] rnd_sum, rnd_shr;
    logic                     sat_hi, sat_lo;

    always_comb begin
        rnd_sum = $signed({res[ACC_BITS-1], res}) + RND;
        rnd_shr = rnd_sum >>> SHIFT;
        sat_hi  = rnd_shr > MAX_OUT;
        sat_lo  = rnd_shr < MIN_OUT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_sat   <= 1'b0;
            out_err   <= 1'b0;
            out_beats <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= res_valid;
            if (res_valid) begin
                out_err   <= res_err;
                out_beats <= res_beats;
                out_sat   <= sat_hi | sat_lo;
                if (sat_hi) begin
                    out <= MAX_OUT[OUT_BITS-1:0];
                end else if (sat_lo) begin
                    out <= MIN_OUT[OUT_BITS-1:0];
                end else begin
                    out <= rnd_shr[OUT_BITS-1:0];
                end
            end
        end
    end
endmodule
